// File: rtl/apb_pkg.sv
// Shared APB types and constants for completer and master.
// State encoding, bus widths and fixed register indices.
package apb_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;
  localparam int IDX_W  = 4;

  localparam logic [1:0] SLAVE_ID_DEF = 2'b01;

  localparam logic [IDX_W-1:0] IDX_STATUS = 4'd0;
  localparam logic [IDX_W-1:0] IDX_CTRL   = 4'd1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    WAIT,
    ACCESS
  } apb_state_e;

endpackage

// File: rtl/apb_if.sv
// APB bus bundle with master/slave modports.
// Optional err signal exists only with APB_SLAVE_ERR_EN.
interface apb_if;
  import apb_pkg::*;

  logic [1:0]        sel;
  logic              enable;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;

`ifdef APB_SLAVE_ERR_EN
  logic              err;

  modport master (
    output sel, enable, write, addr, wdata,
    input  rdata, ready, err
  );

  modport slave (
    input  sel, enable, write, addr, wdata,
    output rdata, ready, err
  );
`else
  modport master (
    output sel, enable, write, addr, wdata,
    input  rdata, ready
  );

  modport slave (
    input  sel, enable, write, addr, wdata,
    output rdata, ready
  );
`endif

endinterface

// File: rtl/apb_regfile.sv
// Register bank: one write port, one read port, status at index 0.
// Indices at or above NUM_REGS read as zero and drop writes.
module apb_regfile
  import apb_pkg::*;
#(
  parameter int NUM_REGS = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  ridx,
  input  logic [DATA_W-1:0] status_in,
  output logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] ctrl
);

  logic [DATA_W-1:0] regs_q [1:NUM_REGS-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (widx == IDX_W'(i)) begin
          regs_q[i] <= wdata;
        end
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (ridx == IDX_W'(i)) begin
        rdata = regs_q[i];
      end
    end
    if (ridx == IDX_STATUS) begin
      rdata = status_in;
    end
  end

  assign ctrl = regs_q[IDX_CTRL];

endmodule

// File: rtl/apb_slave.sv
// APB completer: Moore FSM, wait-state counter, register bank.
// Define APB_SLAVE_ERR_EN to add the err response.
module apb_slave
  import apb_pkg::*;
#(
  parameter logic [1:0] SLAVE_ID    = SLAVE_ID_DEF,
  parameter int         WAIT_CYCLES = 2,
  parameter int         NUM_REGS    = 8
) (
  input  logic              clk,
  input  logic              reset,
  apb_if.slave              bus,
  input  logic [DATA_W-1:0] status_in,
  output logic [DATA_W-1:0] ctrl_out
);

  localparam logic [3:0] WC_LOAD =
    (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  apb_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] rf_rdata;
  logic [IDX_W-1:0]  rd_idx;
  logic              hit;

  assign hit = (bus.sel == SLAVE_ID);

  // Zero-wait reads load rdata straight from the live address.
  assign rd_idx = (state_q == SETUP) ? bus.addr[IDX_W-1:0] : idx_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (hit && !bus.enable) begin
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (!hit) begin
          state_d = IDLE;
        end else if (bus.enable) begin
          idx_d   = bus.addr[IDX_W-1:0];
          wr_d    = bus.write;
          wdata_d = bus.wdata;
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
            cnt_d   = WC_LOAD;
          end else begin
            state_d = ACCESS;
            if (!bus.write) begin
              rdata_d = rf_rdata;
            end
          end
        end
      end
      WAIT: begin
        if (!hit) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == 4'd0) begin
          state_d = ACCESS;
          if (!wr_q) begin
            rdata_d = rf_rdata;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACCESS: begin
        state_d = (hit && !bus.enable) ? SETUP : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  apb_regfile #(
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk       (clk),
    .reset     (reset),
    .we        ((state_q == ACCESS) && wr_q),
    .widx      (idx_q),
    .wdata     (wdata_q),
    .ridx      (rd_idx),
    .status_in (status_in),
    .rdata     (rf_rdata),
    .ctrl      (ctrl_out)
  );

  assign bus.ready = (state_q == ACCESS);
  assign bus.rdata = rdata_q;

`ifdef APB_SLAVE_ERR_EN
  assign bus.err = (state_q == ACCESS) &&
                   (({1'b0, idx_q} >= 5'(NUM_REGS)) ||
                    (wr_q && (idx_q == IDX_STATUS)));
`endif

endmodule

// File: doc/apb_slave.md
APB_SLAVE -- requirements
Module: apb_slave

Interface
REQ-001 SHALL have parameter SLAVE_ID, default 2'b01: sel value that selects this completer.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2: wait states inserted before ready (0..15).
REQ-003 SHALL have parameter NUM_REGS, default 8: register count (2..16).
REQ-004 SHALL have port clk  input  1  sole clock; all logic on posedge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port sel  input  2  completer select from APB master.
REQ-007 SHALL have port enable  input  1  APB access-phase indicator.
REQ-008 SHALL have port write  input  1  1 = write, 0 = read.
REQ-009 SHALL have port addr  input  8  register index; bits [3:0] used.
REQ-010 SHALL have port wdata  input  32  write data.
REQ-011 SHALL have port rdata  output  32  read data.
REQ-012 SHALL have port ready  output  1  transfer-complete strobe.
REQ-013 SHALL have port status_in  input  32  core status, mapped read-only at index 0.
REQ-014 SHALL have port ctrl_out  output  32  contents of register 1, to core.
REQ-015 SHALL have port err  output  1  error response; present only with APB_SLAVE_ERR_EN.

Function
REQ-016 SHALL implement a Moore FSM with states IDLE, SETUP, WAIT, ACCESS; ready = (state==ACCESS).
REQ-017 IDLE->SETUP when sel==SLAVE_ID and enable==0; otherwise remain IDLE.
REQ-018 SETUP->WAIT when enable==1 and WAIT_CYCLES>0, loading wait counter with WAIT_CYCLES-1; SETUP->ACCESS when enable==1 and WAIT_CYCLES==0; hold SETUP while enable==0 and sel==SLAVE_ID.
REQ-019 WAIT decrements counter each cycle; WAIT->ACCESS when counter==0.
REQ-020 ACCESS lasts exactly one cycle; ACCESS->SETUP if sel==SLAVE_ID and enable==0 (back-to-back), else IDLE.
REQ-021 From SETUP or WAIT, sel!=SLAVE_ID SHALL abort to IDLE: no write, no rdata update, ready stays 0.
REQ-022 Latency: ready SHALL go high WAIT_CYCLES+1 cycles after the first cycle with enable==1 sampled in SETUP.
REQ-023 addr, write, wdata SHALL be captured on the SETUP->WAIT/ACCESS edge; later changes are ignored.
REQ-024 Write SHALL commit on the clock edge ending the ACCESS cycle, to index addr[3:0].
REQ-025 Read: rdata SHALL be loaded on the edge entering ACCESS and held until the next read enters ACCESS; writes leave rdata unchanged.
REQ-026 Index 0 reads status_in (sampled on entry to ACCESS); writes to index 0 SHALL be ignored.
REQ-027 Index >= NUM_REGS: reads return 32'h0, writes ignored.
REQ-028 ctrl_out SHALL reflect register 1 from the cycle after its write commits.

Reset
REQ-029 On reset: state=IDLE, counter=0, ready=0, rdata=0, all registers=0, ctrl_out=0, err=0.
REQ-030 Reset mid-transfer SHALL abort it with no register update; reset dominates all other inputs.

Configuration
REQ-031 With APB_SLAVE_ERR_EN defined, err SHALL be 1 only during ACCESS of a transfer to index >= NUM_REGS or a write to index 0, else 0.
REQ-032 Without APB_SLAVE_ERR_EN, port err and its logic SHALL be absent; such accesses complete silently per REQ-026/027.

Structure
REQ-033 State enum, SLAVE_ID default, data/address widths and register index constants (IDX_STATUS=0, IDX_CTRL=1) SHALL live in shared package apb_pkg, also used by the master.
REQ-034 Register bank SHALL be sub-module apb_regfile (write port, one read port, status mux); FSM and wait counter in apb_slave.

Verification
REQ-035 Reset, WAIT_CYCLES=2: write 32'hDEADBEEF to index 3, read index 3 -> ready high 3 cycles after enable, rdata=32'hDEADBEEF.
REQ-036 WAIT_CYCLES=0: write 32'h5 to index 1 -> ready one cycle after enable; ctrl_out=32'h5 next cycle.
REQ-037 status_in=32'hA5A5_0001, write 32'hFFFF_FFFF to index 0, read index 0 -> rdata=32'hA5A5_0001; err=1 on the write with APB_SLAVE_ERR_EN.
REQ-038 Read index 12 (NUM_REGS=8) -> rdata=0, no register changes; err=1 only with macro.
REQ-039 sel set to 2'b10 during WAIT of a write to index 2 -> FSM IDLE next cycle, ready never high, register 2 unchanged.
REQ-040 Back-to-back writes to indices 2,3 without IDLE, then reset asserted in WAIT of a third write -> all registers 0, ready 0, state IDLE.
